// File: rtl/mdu_sched_pkg.sv
// mdu_sched_pkg: shared op/state encodings and divider iteration count for the MDU scheduler
package mdu_sched_pkg;
  typedef enum logic [2:0] {MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU} mdu_op_t;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} mdu_state_t;
  localparam int DIV_ITER = 32;
endpackage

// File: rtl/mdu_sched_if.sv
// mdu_sched_if: EXE-stage pipeline <-> MDU scheduler signal bundle
interface mdu_sched_if import mdu_sched_pkg::*; ();
  logic        op_valid;
  mdu_op_t     op_code;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [63:0] hilo_in;
  logic        flush;
  logic        exe_wr;
  logic        stall;
  logic        busy;
  logic        hilo_we;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  modport master (output op_valid, op_code, src_a, src_b, hilo_in, flush, exe_wr,
                  input  stall, busy, hilo_we, hi_out, lo_out);
  modport slave  (input  op_valid, op_code, src_a, src_b, hilo_in, flush, exe_wr,
                  output stall, busy, hilo_we, hi_out, lo_out);
endinterface

// File: rtl/mdu_sched_div_radix2.sv
// div_radix2: iterative radix-2 restoring divider on magnitudes with a trailing sign-fix cycle
module div_radix2 #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        kill,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  logic        run_q, fix_q, nq_q, nr_q, ge;
  logic [5:0]  cnt_q;
  logic [31:0] rem_q, quo_q, d_q, abs_a, abs_b;
  logic [32:0] sh, diff;
  assign abs_a = signed_op && a[31] ? -a : a;
  assign abs_b = signed_op && b[31] ? -b : b;
  // a zero divisor always "fits", yielding all-ones quotient and |a| remainder
  assign sh    = {rem_q, quo_q[31]};
  assign diff  = sh - {1'b0, d_q};
  assign ge    = ~diff[32];
  assign busy      = run_q | fix_q;
  assign done      = fix_q;
  assign quotient  = nq_q ? -quo_q : quo_q;
  assign remainder = nr_q ? -rem_q : rem_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      fix_q <= 1'b0;
      nq_q  <= 1'b0;
      nr_q  <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      d_q   <= '0;
    end else if (kill) begin
      run_q <= 1'b0;
      fix_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      fix_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= abs_a;
      d_q   <= abs_b;
      nq_q  <= signed_op & (a[31] ^ b[31]);
      nr_q  <= signed_op & a[31];
    end else if (run_q) begin
      rem_q <= ge ? diff[31:0] : sh[31:0];
      quo_q <= {quo_q[30:0], ge};
      cnt_q <= cnt_q + 6'd1;
      run_q <= cnt_q != 6'(ITER - 1);
      fix_q <= cnt_q == 6'(ITER - 1);
    end else begin
      fix_q <= 1'b0;
    end
  end
endmodule

// File: rtl/mdu_sched.sv
// mdu_sched: EXE-stage multiply/divide sequencer with accumulate, flush abort and single HI/LO commit
module mdu_sched import mdu_sched_pkg::*; #(
  parameter int MUL_LAT = 2
) (
  input  logic clk,
  input  logic resetn,
  mdu_sched_if.slave bus
);
  mdu_state_t  state_q;
  mdu_op_t     op_q;
  logic [31:0] a_q, b_q, hi_q, lo_q, quo, rem;
  logic [2:0]  cnt_q;
  logic [63:0] prod, acc;
  logic        sgn, is_div, start, div_busy, div_done;
  assign sgn    = ~op_q[0];
  assign is_div = bus.op_code inside {DIV, DIVU};
  assign start  = state_q == S_IDLE && bus.op_valid && !bus.flush && is_div;
  // low 64 bits of the extended product are correct for both signednesses
  assign prod = {{32{sgn & a_q[31]}}, a_q} * {{32{sgn & b_q[31]}}, b_q};
  assign acc  = op_q inside {MADD, MADDU} ? bus.hilo_in + prod :
                op_q inside {MSUB, MSUBU} ? bus.hilo_in - prod : prod;
  assign bus.stall   = state_q == S_IDLE ? bus.op_valid : state_q != S_DONE;
  assign bus.busy    = state_q == S_MUL || div_busy;
  assign bus.hilo_we = state_q == S_DONE && bus.exe_wr && !bus.flush;
  assign bus.hi_out  = hi_q;
  assign bus.lo_out  = lo_q;
  div_radix2 #(.ITER(DIV_ITER)) u_div (
    .clk       (clk),
    .rst_n     (resetn),
    .start     (start),
    .signed_op (~bus.op_code[0]),
    .a         (bus.src_a),
    .b         (bus.src_b),
    .kill      (bus.flush),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      op_q    <= MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else if (bus.flush) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.op_valid) begin
          op_q    <= bus.op_code;
          a_q     <= bus.src_a;
          b_q     <= bus.src_b;
          cnt_q   <= is_div ? 3'd0 : 3'd1;
          state_q <= is_div ? S_DIV : S_MUL;
        end
        S_MUL: if (cnt_q == 3'(MUL_LAT)) begin
          {hi_q, lo_q} <= acc;
          cnt_q        <= '0;
          state_q      <= S_DONE;
        end else begin
          cnt_q <= cnt_q + 3'd1;
        end
        S_DIV: if (div_done) begin
          hi_q    <= rem;
          lo_q    <= quo;
          state_q <= S_DONE;
        end
        S_DONE: if (bus.exe_wr) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
